// File: rtl/regfile_pkg.sv
// regfile_pkg: FunSel codes and the shared next-register-value helper
package regfile_pkg;
  localparam int FUN_W = 3;
  localparam int MAX_W = 1024;
  typedef enum logic [FUN_W-1:0] {
    F_DEC, F_INC, F_LOAD, F_CLR, F_LDB_Z, F_LDB_H, F_SHB, F_LDB_S
  } fun_e;
  // Operands are zero-extended to MAX_W; callers truncate back to WIDTH, which keeps
  // inc/dec modulo 2^WIDTH and makes the byte shift drop the top byte naturally.
  function automatic logic [MAX_W-1:0] next_value(input logic [MAX_W-1:0] cur, input fun_e f,
                                                  input logic [MAX_W-1:0] i);
    return f == F_DEC   ? cur - MAX_W'(1) :
           f == F_INC   ? cur + MAX_W'(1) :
           f == F_LOAD  ? i :
           f == F_CLR   ? '0 :
           f == F_LDB_Z ? MAX_W'(i[7:0]) :
           f == F_LDB_H ? {cur[MAX_W-1:8], i[7:0]} :
           f == F_SHB   ? {cur[MAX_W-9:0], i[7:0]} :
                          {{(MAX_W-8){i[7]}}, i[7:0]};
  endfunction
endpackage

// File: rtl/param_register_file_if.sv
// param_register_file_if: control-unit / ALU-side bus of the register file
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_R = 4,
  parameter int NUM_S = 4
);
  localparam int SEL_W = $clog2(NUM_R + NUM_S);
  logic [FUN_W-1:0] FunSel;
  logic [NUM_R-1:0] RegSel;
  logic [NUM_S-1:0] ScrSel;
  logic [SEL_W-1:0] OutASel;
  logic [SEL_W-1:0] OutBSel;
  logic [WIDTH-1:0] I;
  logic             ClrFlags;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             ValidA;
  logic             ValidB;
  logic             WrapFlag;
  modport master (
    output FunSel, RegSel, ScrSel, OutASel, OutBSel, I, ClrFlags,
    input  OutA, OutB, ValidA, ValidB, WrapFlag
  );
  modport slave (
    input  FunSel, RegSel, ScrSel, OutASel, OutBSel, I, ClrFlags,
    output OutA, OutB, ValidA, ValidB, WrapFlag
  );
endinterface

// File: rtl/rf_cell.sv
// rf_cell: one register with its written flag and a same-cycle wrap pulse
module rf_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             E,
  input  logic [FUN_W-1:0] FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Written,
  output logic             Wrap
);
  logic [WIDTH-1:0] d;
  assign d = WIDTH'(next_value(MAX_W'(Q), fun_e'(FunSel), MAX_W'(I)));
  assign Wrap = E && ((FunSel == F_INC && &Q) || (FunSel == F_DEC && Q == '0));
  // Enabled cells take the FunSel result; clear is the only op that drops the written flag.
  always_ff @(posedge Clock)
    if (!rst) begin
      Q       <= '0;
      Written <= 1'b0;
    end else if (E) begin
      Q       <= d;
      Written <= FunSel != F_CLR;
    end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: NUM_R general + NUM_S scratch registers with two combinational read ports
module param_register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_R  = 4,
  parameter int NUM_S  = 4,
  parameter int BYPASS = 0
) (
  input logic Clock,
  input logic rst,
  param_register_file_if.slave bus
);
  localparam int N = NUM_R + NUM_S;
  localparam int SEL_W = $clog2(N);
  localparam int M = 2 ** SEL_W;
  logic [N-1:0]     en;
  logic [N-1:0]     wrap;
  logic [WIDTH-1:0] view_q [M];
  logic             view_w [M];
  logic             wrap_flag;
  assign en = {bus.ScrSel, bus.RegSel};
  // Select codes past the last register map to padding entries that read as 0 / not written.
  for (genvar j = 0; j < M; j++) begin : g_reg
    if (j < N) begin : g_cell
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] nq;
      logic             w;
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .Clock, .rst, .E(en[j]), .FunSel(bus.FunSel), .I(bus.I), .Q(q), .Written(w), .Wrap(wrap[j])
      );
      assign nq = WIDTH'(next_value(MAX_W'(q), fun_e'(bus.FunSel), MAX_W'(bus.I)));
      assign view_q[j] = BYPASS != 0 && en[j] ? nq : q;
      assign view_w[j] = BYPASS != 0 && en[j] ? bus.FunSel != F_CLR : w;
    end else begin : g_pad
      assign view_q[j] = '0;
      assign view_w[j] = 1'b0;
    end
  end
  assign bus.OutA     = view_q[bus.OutASel];
  assign bus.OutB     = view_q[bus.OutBSel];
  assign bus.ValidA   = view_w[bus.OutASel];
  assign bus.ValidB   = view_w[bus.OutBSel];
  assign bus.WrapFlag = wrap_flag;
  // Sticky wrap: a new wrap pulse beats ClrFlags in the same cycle.
  always_ff @(posedge Clock)
    if (!rst) wrap_flag <= 1'b0;
    else wrap_flag <= |wrap || (wrap_flag && !bus.ClrFlags);
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: scoreboard bench for default, bypass and 6/2 builds
module tb_param_register_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;
  param_register_file_if #(.WIDTH(32), .NUM_R(4), .NUM_S(4)) bus ();
  param_register_file_if #(.WIDTH(32), .NUM_R(3), .NUM_S(2)) bp ();
  param_register_file_if #(.WIDTH(32), .NUM_R(6), .NUM_S(2)) wd ();
  param_register_file #(.WIDTH(32), .NUM_R(4), .NUM_S(4), .BYPASS(0)) dut (.Clock(clk), .rst(rst), .bus(bus));
  param_register_file #(.WIDTH(32), .NUM_R(3), .NUM_S(2), .BYPASS(1)) dut_bp (.Clock(clk), .rst(rst), .bus(bp));
  param_register_file #(.WIDTH(32), .NUM_R(6), .NUM_S(2), .BYPASS(0)) dut_wd (.Clock(clk), .rst(rst), .bus(wd));
  typedef struct {
    logic [31:0] a;
    logic        va;
    logic [31:0] b;
    logic        vb;
    logic        wf;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] m_q [8];
  logic        m_w [8];
  logic        m_wrap;
  int          errors = 0;
  int          checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_next(input logic [31:0] r, input logic [2:0] f, input logic [31:0] d);
    case (f)
      3'd0: return r - 32'd1;
      3'd1: return r + 32'd1;
      3'd2: return d;
      3'd3: return 32'd0;
      3'd4: return {24'd0, d[7:0]};
      3'd5: return {r[31:8], d[7:0]};
      3'd6: return {r[23:0], d[7:0]};
      default: return {{24{d[7]}}, d[7:0]};
    endcase
  endfunction
  task automatic step(input logic r, input logic [2:0] f, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [31:0] d, input logic clr);
    logic       any;
    logic [7:0] en;
    @(negedge clk);
    rst = r;
    bus.FunSel = f;
    bus.RegSel = rs;
    bus.ScrSel = ss;
    bus.I = d;
    bus.ClrFlags = clr;
    en = {ss, rs};
    @(posedge clk);
    any = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!r) begin
        m_q[k] = 32'd0;
        m_w[k] = 1'b0;
      end else if (en[k]) begin
        if ((f == 3'd1 && m_q[k] == 32'hFFFFFFFF) || (f == 3'd0 && m_q[k] == 32'd0)) any = 1'b1;
        m_q[k] = model_next(m_q[k], f, d);
        m_w[k] = f != 3'd3;
      end
    end
    m_wrap = !r ? 1'b0 : (any || (m_wrap && !clr));
    #1;
    rst = 1'b1;
    bus.RegSel = '0;
    bus.ScrSel = '0;
    bus.ClrFlags = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    bus.OutASel = a;
    bus.OutBSel = b;
    sb.push_back('{m_q[a], m_w[a], m_q[b], m_w[b], m_wrap});
    #1;
    e = sb.pop_front();
    check($sformatf("outa[%0d]", a), bus.OutA, e.a);
    check($sformatf("valida[%0d]", a), 32'(bus.ValidA), 32'(e.va));
    check($sformatf("outb[%0d]", b), bus.OutB, e.b);
    check($sformatf("validb[%0d]", b), 32'(bus.ValidB), 32'(e.vb));
    check("wrapflag", 32'(bus.WrapFlag), 32'(e.wf));
  endtask
  initial begin
    logic [31:0] d;
    {bus.FunSel, bus.RegSel, bus.ScrSel, bus.OutASel, bus.OutBSel, bus.I, bus.ClrFlags} = '0;
    {bp.FunSel, bp.RegSel, bp.ScrSel, bp.OutASel, bp.OutBSel, bp.I, bp.ClrFlags} = '0;
    {wd.FunSel, wd.RegSel, wd.ScrSel, wd.OutASel, wd.OutBSel, wd.I, wd.ClrFlags} = '0;
    step(1'b0, 3'd2, 4'hF, 4'hF, 32'hA5A5A5A5, 1'b0);
    rd(0, 1); rd(4, 7);
    step(1'b1, 3'd2, 4'b0001, 4'b0000, 32'h12345678, 1'b0);
    rd(0, 1);
    check("tp_load_outa", bus.OutA, 32'h12345678);
    check("tp_load_validb", 32'(bus.ValidB), 32'd0);
    step(1'b1, 3'd2, 4'b0010, 4'b0000, 32'hFFFFFFFF, 1'b0);
    step(1'b1, 3'd1, 4'b0010, 4'b0000, 32'h0, 1'b0);
    rd(1, 2);
    check("tp_inc_wrap", 32'(bus.WrapFlag), 32'd1);
    step(1'b1, 3'd0, 4'b0100, 4'b0000, 32'h0, 1'b1);
    rd(2, 1);
    check("tp_dec_wrap_val", bus.OutA, 32'hFFFFFFFF);
    check("tp_set_beats_clr", 32'(bus.WrapFlag), 32'd1);
    step(1'b1, 3'd2, 4'b0000, 4'b0000, 32'h0, 1'b1);
    rd(2, 3);
    check("tp_clr_flags", 32'(bus.WrapFlag), 32'd0);
    step(1'b1, 3'd6, 4'b0000, 4'b0001, 32'h000000DE, 1'b0);
    step(1'b1, 3'd6, 4'b0000, 4'b0001, 32'h111111AD, 1'b0);
    step(1'b1, 3'd6, 4'b0000, 4'b0001, 32'h222222BE, 1'b0);
    step(1'b1, 3'd6, 4'b0000, 4'b0001, 32'h333333EF, 1'b0);
    rd(4, 5);
    check("tp_byte_asm", bus.OutA, 32'hDEADBEEF);
    step(1'b1, 3'd7, 4'b0000, 4'b0001, 32'h00000080, 1'b0);
    rd(4, 0);
    check("tp_sext", bus.OutA, 32'hFFFFFF80);
    step(1'b1, 3'd5, 4'b0000, 4'b0001, 32'hABCDEF12, 1'b0);
    rd(4, 0);
    step(1'b1, 3'd4, 4'b0000, 4'b0001, 32'hABCDEF34, 1'b0);
    rd(4, 0);
    step(1'b1, 3'd2, 4'hF, 4'hF, 32'hA5A5A5A5, 1'b0);
    for (int k = 0; k < 8; k += 2) rd(3'(k), 3'(k + 1));
    check("tp_all_load", bus.OutB, 32'hA5A5A5A5);
    step(1'b1, 3'd3, 4'b0000, 4'b1000, 32'h0, 1'b0);
    rd(7, 6);
    check("tp_clr_s4", bus.OutA, 32'd0);
    check("tp_clr_s4_valid", 32'(bus.ValidA), 32'd0);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: d = 32'd0;
        1: d = 32'hFFFFFFFF;
        default: d = $urandom;
      endcase
      step($urandom_range(0, 15) != 0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), d,
           1'($urandom_range(0, 1)));
      rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    step(1'b1, 3'd2, 4'hF, 4'hF, 32'hFFFFFFFF, 1'b0);
    step(1'b1, 3'd1, 4'b0001, 4'b0000, 32'h0, 1'b0);
    step(1'b1, 3'd6, 4'b0000, 4'b0010, 32'h000000DE, 1'b0);
    step(1'b0, 3'd2, 4'hF, 4'h0, 32'h12345678, 1'b0);
    for (int k = 0; k < 8; k += 2) rd(3'(k), 3'(k + 1));
    check("tp_rst_outa", bus.OutA, 32'd0);
    check("tp_rst_wrap", 32'(bus.WrapFlag), 32'd0);
    @(negedge clk);
    bp.FunSel = 3'd2;
    bp.RegSel = 3'b001;
    bp.I = 32'hCAFEF00D;
    bp.OutASel = 3'd0;
    bp.OutBSel = 3'd6;
    #1;
    check("bp_outa_pre", bp.OutA, 32'hCAFEF00D);
    check("bp_valida_pre", 32'(bp.ValidA), 32'd1);
    check("bp_outb_oor", bp.OutB, 32'd0);
    check("bp_validb_oor", 32'(bp.ValidB), 32'd0);
    @(posedge clk);
    #1;
    bp.RegSel = '0;
    bp.OutBSel = 3'd1;
    #1;
    check("bp_outa_held", bp.OutA, 32'hCAFEF00D);
    check("bp_validb_unwritten", 32'(bp.ValidB), 32'd0);
    @(negedge clk);
    bp.FunSel = 3'd3;
    bp.RegSel = 3'b001;
    bp.OutBSel = 3'd5;
    #1;
    check("bp_clr_outa", bp.OutA, 32'd0);
    check("bp_clr_valida", 32'(bp.ValidA), 32'd0);
    check("bp_outb_sel5", bp.OutB, 32'd0);
    @(posedge clk);
    #1;
    bp.RegSel = '0;
    @(negedge clk);
    wd.FunSel = 3'd2;
    wd.ScrSel = 2'b10;
    wd.I = 32'h5A5A0001;
    @(posedge clk);
    #1;
    wd.ScrSel = '0;
    wd.OutASel = 3'd7;
    wd.OutBSel = 3'd6;
    #1;
    check("wd_s2_val", wd.OutA, 32'h5A5A0001);
    check("wd_s2_valid", 32'(wd.ValidA), 32'd1);
    check("wd_s1_val", wd.OutB, 32'd0);
    check("wd_s1_valid", 32'(wd.ValidB), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor of the datapath register file. Holds NUM_R general registers and NUM_S scratch registers of WIDTH bits each, and exposes two combinational read ports. Adds an 8-operation function set, per-register written flags, a sticky wrap flag and optional write-through bypass on the read ports. It sits between the ALU result bus (I) and the ALU operand muxes, and is driven directly by the control unit.

## Interface
- WIDTH, 32: register width; multiple of 8, at least 16.
- NUM_R, 4: general register count, at least 1.
- NUM_S, 4: scratch register count, at least 1.
- BYPASS, 0: when 1, read ports return the value being written this cycle.
- SEL_W, derived as clog2(NUM_R+NUM_S): width of the read selects. Not overridable.

- Clock  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- FunSel  in  3  operation applied to every enabled register.
- RegSel  in  NUM_R  per-general-register enable; bit i enables Ri.
- ScrSel  in  NUM_S  per-scratch-register enable; bit j enables Sj.
- OutASel  in  SEL_W  read port A select; 0..NUM_R-1 selects Ri, NUM_R..NUM_R+NUM_S-1 selects Sj.
- OutBSel  in  SEL_W  read port B select; same encoding as OutASel.
- I  in  WIDTH  write data.
- ClrFlags  in  1  clears WrapFlag.
- OutA  out  WIDTH  read data, port A.
- OutB  out  WIDTH  read data, port B.
- ValidA  out  1  selected register has been written since reset.
- ValidB  out  1  same as ValidA, for port B.
- WrapFlag  out  1  sticky; set when an enabled increment or decrement wraps.

## Operation
- FunSel codes, applied to every register whose enable is 1; all other registers hold:
  - 000: decrement.
  - 001: increment.
  - 010: load I.
  - 011: clear.
  - 100: load I[7:0], upper bits cleared.
  - 101: load I[7:0], upper bits held.
  - 110: shift the register left 8 bits, then insert I[7:0] (byte assemble).
  - 111: load I[7:0], sign-extended to WIDTH.
- Any number of R and S enables may be active in the same cycle; each enabled register executes the same FunSel independently.
- Written flag, one per register:
  - Set by any enabled operation except 011 (clear).
  - Cleared by 011 and by reset.
- WrapFlag:
  - Set when any enabled register goes from all-ones to 0 on increment, or from 0 to all-ones on decrement.
  - Set and ClrFlags in the same cycle: set wins.
- Read ports:
  - A select value at or above NUM_R+NUM_S gives OutX = 0 and ValidX = 0.
  - Both ports may select the same register.
- BYPASS=1: if the selected register is enabled this cycle, OutX shows its next-state value and ValidX shows its next-state written flag. BYPASS=0: current state is shown.

## Timing
- Reset: when rst=0 at a rising edge, all registers, written flags and WrapFlag go to 0, whatever the enables are. After reset, OutA=OutB=0 and ValidA=ValidB=0.
- Write latency is one cycle: a value is visible on the read ports the cycle after the edge, or in the same cycle when BYPASS=1.
- Reads are purely combinational from the selects and state; there are no read stalls or handshakes.
- Reset asserted mid-sequence (for example during a byte-assemble series) discards all partial state; there is no recovery of earlier contents.
- Increment and decrement wrap modulo 2^WIDTH; no saturation.

## Structure
- Shared package regfile_pkg holds:
  - The FunSel code constants.
  - A helper function computing the next register value from (current value, FunSel, I).
- One natural sub-module, rf_cell. Parameter WIDTH. Ports: Clock, rst, E, FunSel, I, Q, Written, Wrap (combinational wrap pulse for this cycle).
- The top level:
  - Instantiates NUM_R + NUM_S rf_cell instances via a generate loop.
  - ORs the Wrap pulses into the WrapFlag register.
  - Implements the two read muxes, including the bypass path.

## Test plan
- Reset, then RegSel=0001, FunSel=010, I=0x12345678 -> next cycle OutASel=0 gives OutA=0x12345678, ValidA=1; OutBSel=1 gives OutB=0, ValidB=0.
- R2 loaded with 0xFFFFFFFF, then FunSel=001 on R2 -> R2=0, WrapFlag=1. Next cycle ClrFlags=1 with FunSel=000 on R3=0 -> R3=0xFFFFFFFF, WrapFlag stays 1.
- S1 byte assemble: I[7:0] = 0xDE, 0xAD, 0xBE, 0xEF on four FunSel=110 cycles -> S1=0xDEADBEEF. Then FunSel=111 with I[7:0]=0x80 -> 0xFFFFFF80.
- RegSel=1111 and ScrSel=1111 with FunSel=010, I=0xA5A5A5A5 -> all eight selects read 0xA5A5A5A5. Then FunSel=011 on S4 only -> OutASel=7 gives 0 with ValidA=0.
- BYPASS=1 build: in the same cycle as a load of 0xCAFEF00D into R1 with OutASel=0 -> OutA=0xCAFEF00D and ValidA=1 before the edge.
- rst=0 asserted in a cycle where RegSel=1111 and FunSel=010 -> all registers 0 afterwards, ValidA=0, WrapFlag=0. NUM_R=6, NUM_S=2 build: select 7 reads S2, and all selects are in range.
